fmap_loader: RTL and testbench

- Front-end stage directly upstream of the LeNet-5 top. It accepts a raster-order pixel stream with a valid/ready handshake and assembles one full I_SIZE x I_SIZE frame into the flattened feature-map bus.
- It then enables inference via o_ce, waits for the done pulse, and returns the 4-bit class result through a valid/ready output handshake.
- The sequence repeats per frame. A watchdog guards against a missing done pulse.

---
 rtl/fmap_loader.sv | 165 ++++++++++++++++
 tb/tb_fmap_loader.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_loader.sv
// Pixel-stream front end for the LeNet-5 core: collects one raster-order frame
// into the flattened feature-map bus, runs the core under a watchdog and hands
// the class result downstream over a valid/ready handshake.
module fmap_loader #(
    parameter int I_SIZE      = 28,
    parameter int I_BW        = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                          clk,
    input  logic                          global_rst_n,
    input  logic                          i_pix_valid,
    input  logic [I_BW-1:0]               i_pix_data,
    input  logic                          i_pix_last,
    output logic                          o_pix_ready,
    output logic [I_SIZE*I_SIZE*I_BW-1:0] o_fmap,
    output logic                          o_ce,
    input  logic                          i_end,
    input  logic [3:0]                    i_result,
    output logic                          o_result_valid,
    output logic [3:0]                    o_result,
    input  logic                          i_result_ready,
    output logic                          o_frame_err,
    output logic                          o_timeout
);

    localparam int N  = I_SIZE * I_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_next;
    logic [WW-1:0]     r_wdog;
    logic [WW-1:0]     w_wdog_next;
    logic [3:0]        r_result;
    logic [3:0]        w_result_next;
    logic              r_result_valid;
    logic              w_result_valid_next;
    logic              r_pix_ready;
    logic              r_ce;
    logic              r_frame_err;
    logic              w_frame_err_next;
    logic              r_timeout;
    logic              w_timeout_next;
    logic              w_xfer;
    logic              w_pix_write;
    logic [N*I_BW-1:0] r_fmap;

    // Next-state and next-register decisions: framing checks while loading,
    // done/watchdog race while running (done wins), result handshake afterwards.
    always_comb begin
        w_state_next        = r_state;
        w_count_next        = r_count;
        w_wdog_next         = '0;
        w_result_next       = r_result;
        w_result_valid_next = r_result_valid;
        w_frame_err_next    = 1'b0;
        w_timeout_next      = 1'b0;
        w_pix_write         = 1'b0;
        w_xfer              = (r_state == S_LOAD) && r_pix_ready && i_pix_valid;

        case (r_state)
            S_LOAD: begin
                if (w_xfer) begin
                    if (i_pix_last != (r_count == LAST_IDX)) begin
                        w_count_next     = '0;
                        w_frame_err_next = 1'b1;
                    end else if (i_pix_last) begin
                        w_pix_write  = 1'b1;
                        w_count_next = '0;
                        w_state_next = S_RUN;
                    end else begin
                        w_pix_write  = 1'b1;
                        w_count_next = r_count + CW'(1);
                    end
                end
            end
            S_RUN: begin
                if (i_end) begin
                    w_result_next       = i_result;
                    w_result_valid_next = 1'b1;
                    w_state_next        = S_RESULT;
                end else if (r_wdog == WD_LIMIT) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = S_LOAD;
                end else begin
                    w_wdog_next = r_wdog + WW'(1);
                end
            end
            S_RESULT: begin
                if (i_result_ready) begin
                    w_result_valid_next = 1'b0;
                    w_state_next        = S_LOAD;
                end
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters and registered outputs; ready/ce follow the state being entered.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_count        <= '0;
            r_wdog         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_pix_ready    <= 1'b0;
            r_ce           <= 1'b0;
            r_frame_err    <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_count        <= w_count_next;
            r_wdog         <= w_wdog_next;
            r_result       <= w_result_next;
            r_result_valid <= w_result_valid_next;
            r_pix_ready    <= (w_state_next == S_LOAD);
            r_ce           <= (w_state_next == S_RUN);
            r_frame_err    <= w_frame_err_next;
            r_timeout      <= w_timeout_next;
        end
    end

    // Frame store: each accepted pixel lands in the slot selected by the counter.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_fmap <= '0;
        end else if (w_pix_write) begin
            for (int k = 0; k < N; k++) begin
                if (r_count == CW'(k)) begin
                    r_fmap[k*I_BW +: I_BW] <= i_pix_data;
                end
            end
        end
    end

    assign o_pix_ready    = r_pix_ready;
    assign o_fmap         = r_fmap;
    assign o_ce           = r_ce;
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_frame_err    = r_frame_err;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_fmap_loader.sv
// Self-checking bench for fmap_loader: a transaction-level model of the frame
// loader is compared against the DUT on every cycle, plus literal checks.
`timescale 1ns/1ps
module tb_fmap_loader;

    localparam int ISIZE = 28;
    localparam int BW    = 8;
    localparam int TMO   = 16;
    localparam int N     = ISIZE * ISIZE;

    localparam int PH_LOAD = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_HOLD = 2;

    logic                clk = 1'b0;
    logic                globalRstN = 1'b0;
    logic                pixValid = 1'b0;
    logic [BW-1:0]       pixData = '0;
    logic                pixLast = 1'b0;
    logic                pixReady;
    logic [N*BW-1:0]     fmap;
    logic                ce;
    logic                endPulse = 1'b0;
    logic [3:0]          resultIn = '0;
    logic                resultValid;
    logic [3:0]          resultOut;
    logic                resultReady = 1'b0;
    logic                frameErr;
    logic                timeoutPulse;

    int errors = 0;
    int checks = 0;

    logic [7:0] mFmap [N];
    int         mCount;
    int         mPhase;
    int         mRunCycles;
    logic       mReady;
    logic       mCe;
    logic       mValid;
    logic [3:0] mResult;
    logic       mErr;
    logic       mTimeout;

    fmap_loader #(
        .I_SIZE(ISIZE),
        .I_BW(BW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .global_rst_n(globalRstN),
        .i_pix_valid(pixValid),
        .i_pix_data(pixData),
        .i_pix_last(pixLast),
        .o_pix_ready(pixReady),
        .o_fmap(fmap),
        .o_ce(ce),
        .i_end(endPulse),
        .i_result(resultIn),
        .o_result_valid(resultValid),
        .o_result(resultOut),
        .i_result_ready(resultReady),
        .o_frame_err(frameErr),
        .o_timeout(timeoutPulse)
    );

    always #5 clk = ~clk;

    // Model: everything back to power-on values.
    function automatic void modelReset();
        for (int k = 0; k < N; k++) mFmap[k] = 8'h00;
        mCount     = 0;
        mPhase     = PH_LOAD;
        mRunCycles = 0;
        mReady     = 1'b0;
        mCe        = 1'b0;
        mValid     = 1'b0;
        mResult    = 4'h0;
        mErr       = 1'b0;
        mTimeout   = 1'b0;
    endfunction

    // Model: one clock of frame-level behaviour from the current inputs.
    function automatic void modelStep();
        logic err;
        logic tmo;
        err = 1'b0;
        tmo = 1'b0;
        if (mPhase == PH_LOAD) begin
            if (mReady && pixValid) begin
                if (pixLast && mCount == N - 1) begin
                    mFmap[mCount] = pixData;
                    mCount        = 0;
                    mPhase        = PH_RUN;
                    mRunCycles    = 0;
                end else if (pixLast || mCount == N - 1) begin
                    mCount = 0;
                    err    = 1'b1;
                end else begin
                    mFmap[mCount] = pixData;
                    mCount++;
                end
            end
        end else if (mPhase == PH_RUN) begin
            if (endPulse) begin
                mResult = resultIn;
                mValid  = 1'b1;
                mPhase  = PH_HOLD;
            end else if (mRunCycles == TMO - 1) begin
                tmo    = 1'b1;
                mPhase = PH_LOAD;
            end else begin
                mRunCycles++;
            end
        end else begin
            if (resultReady) begin
                mValid = 1'b0;
                mPhase = PH_LOAD;
            end
        end
        mErr     = err;
        mTimeout = tmo;
        mCe      = (mPhase == PH_RUN);
        mReady   = (mPhase == PH_LOAD);
    endfunction

    // Model clocking, with asynchronous reset like the real block.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge globalRstN);
            if (!globalRstN) modelReset();
            else modelStep();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmpFmapModel();
        int bad;
        bad = -1;
        for (int k = 0; k < N; k++) begin
            if (fmap[k*BW +: BW] !== mFmap[k]) begin
                bad = k;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL fmap_model slot %0d: got %h expected %h at %0t",
                     bad, fmap[bad*BW +: BW], mFmap[bad], $time);
        end
    endtask

    task automatic literalFrameCheck(input string name);
        int bad;
        logic [7:0] e;
        bad = -1;
        for (int k = 0; k < N; k++) begin
            e = 8'(k);
            if (fmap[k*BW +: BW] !== e) begin
                bad = k;
                break;
            end
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s slot %0d: got %h expected %h", name, bad,
                     fmap[bad*BW +: BW], 8'(bad));
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_ce"}, ce, 0);
        checkOutput({name, "_pix_ready"}, pixReady, 0);
        checkOutput({name, "_result_valid"}, resultValid, 0);
        checkOutput({name, "_result"}, resultOut, 0);
        checkOutput({name, "_frame_err"}, frameErr, 0);
        checkOutput({name, "_timeout"}, timeoutPulse, 0);
        checks++;
        if (fmap !== '0) begin
            errors++;
            $display("[TB] FAIL %s_fmap: got nonzero frame store expected all zero", name);
        end
    endtask

    // Compare process: DUT against the model on every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (globalRstN) begin
                checkOutput("pix_ready", pixReady, mReady);
                checkOutput("ce", ce, mCe);
                checkOutput("result_valid", resultValid, mValid);
                checkOutput("result", resultOut, mResult);
                checkOutput("frame_err", frameErr, mErr);
                checkOutput("timeout", timeoutPulse, mTimeout);
                cmpFmapModel();
            end
        end
    end

    task automatic finishRun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("[TB] FAIL global_time_limit: simulation did not complete");
        finishRun();
    end

    // One pixel offered until accepted; valid is dropped randomly per pct.
    task automatic applyStimulus(input logic [7:0] d, input logic l, input int pct, output bit ok);
        bit hs;
        int tries;
        hs    = 1'b0;
        tries = 0;
        while (!hs && tries < 400) begin
            if (int'($urandom_range(1, 100)) <= pct) begin
                pixValid = 1'b1;
                pixData  = d;
                pixLast  = l;
            end else begin
                pixValid = 1'b0;
                pixData  = 8'($urandom);
                pixLast  = 1'($urandom);
            end
            endPulse    = ($urandom_range(0, 7) == 0);
            resultReady = 1'($urandom);
            resultIn    = 4'($urandom);
            @(negedge clk);
            hs = pixValid && pixReady;
            @(posedge clk);
            #1;
            tries++;
        end
        pixValid    = 1'b0;
        endPulse    = 1'b0;
        resultReady = 1'b0;
        ok          = hs;
        if (!hs) begin
            checks++;
            errors++;
            $display("[TB] FAIL handshake_wait: got no acceptance expected pixel taken within 400 cycles");
        end
    endtask

    task automatic sendFrame(input bit randomData, input int pct, input int count, input int lastAt);
        bit ok;
        logic [7:0] d;
        for (int k = 0; k < count; k++) begin
            d = randomData ? 8'($urandom) : 8'(k);
            applyStimulus(d, (k == lastAt), pct, ok);
            if (!ok) finishRun();
        end
    endtask

    // Called at the start of a RUN cycle; i_end goes high endDelay cycles later.
    task automatic runInference(input int endDelay, input logic [3:0] res, input int readyDelay);
        int validCount;
        validCount = 0;
        for (int i = 0; i < endDelay; i++) begin
            pixValid    = 1'b1;
            pixData     = 8'($urandom);
            pixLast     = 1'($urandom);
            resultReady = 1'($urandom);
            @(posedge clk);
            #1;
        end
        pixValid    = 1'b0;
        endPulse    = 1'b1;
        resultIn    = res;
        resultReady = 1'b0;
        @(posedge clk);
        #1;
        endPulse = 1'b0;
        resultIn = 4'($urandom);
        for (int c = 0; c <= readyDelay; c++) begin
            resultReady = (c == readyDelay);
            @(negedge clk);
            if (c == 0) begin
                checkOutput("result_latched", resultOut, res);
                checkOutput("ce_falls_after_end", ce, 0);
                checkOutput("no_timeout_on_end", timeoutPulse, 0);
            end
            if (resultValid) validCount++;
            @(posedge clk);
            #1;
        end
        resultReady = 1'b0;
        @(negedge clk);
        checkOutput("valid_cycles", validCount, readyDelay + 1);
        checkOutput("valid_dropped", resultValid, 0);
        checkOutput("ready_after_result", pixReady, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        globalRstN = 1'b1;
        @(negedge clk);
        checkOutput("ready_low_before_edge", pixReady, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ready_after_release", pixReady, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ceCount;
        bit seen;

        #12;
        checkAllZero("reset");
        releaseReset();

        // Full-rate frame with value k mod 256, then result with delayed ready.
        sendFrame(1'b0, 100, N, N - 1);
        @(negedge clk);
        checkOutput("ce_one_cycle_after_last", ce, 1);
        checkOutput("ready_low_in_run", pixReady, 0);
        literalFrameCheck("frame_k_mod_256");
        @(posedge clk);
        #1;
        runInference(3, 4'd7, 5);

        // Premature last on pixel 99, then a clean frame.
        sendFrame(1'b1, 100, 100, 99);
        @(negedge clk);
        checkOutput("frame_err_early_last", frameErr, 1);
        checkOutput("no_run_after_err", ce, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("frame_err_one_cycle", frameErr, 0);
        @(posedge clk);
        #1;
        sendFrame(1'b1, 100, N, N - 1);
        @(negedge clk);
        checkOutput("ce_after_recovered_frame", ce, 1);
        @(posedge clk);
        #1;
        runInference($urandom_range(0, 13), 4'($urandom), $urandom_range(0, 3));

        // Full frame length with no last marker.
        sendFrame(1'b1, 100, N, -1);
        @(negedge clk);
        checkOutput("frame_err_missing_last", frameErr, 1);
        checkOutput("no_run_without_last", ce, 0);
        @(posedge clk);
        #1;

        // Gappy valid with the k mod 256 pattern over a store holding random data.
        sendFrame(1'b0, 50, N, N - 1);
        @(negedge clk);
        literalFrameCheck("frame_random_valid");
        checkOutput("ce_after_gappy_frame", ce, 1);
        @(posedge clk);
        #1;
        runInference($urandom_range(0, 13), 4'($urandom), $urandom_range(0, 3));

        // Watchdog expiry with no done pulse.
        sendFrame(1'b1, 100, N, N - 1);
        ceCount = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (timeoutPulse) begin
                seen = 1'b1;
                checkOutput("ce_low_at_timeout", ce, 0);
                checkOutput("no_result_on_timeout", resultValid, 0);
            end else if (ce) begin
                ceCount++;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("timeout_seen", seen, 1);
        checkOutput("ce_cycles_before_timeout", ceCount, TMO);

        // Done pulse on the last watchdog cycle beats the timeout.
        sendFrame(1'b1, 100, N, N - 1);
        runInference(TMO - 1, 4'd12, 2);

        // Reset in the middle of loading.
        sendFrame(1'b1, 100, 401, -1);
        #2;
        globalRstN = 1'b0;
        #1;
        checkAllZero("reset_mid_load");
        releaseReset();
        sendFrame(1'b0, 100, N, N - 1);
        @(negedge clk);
        literalFrameCheck("frame_after_reset");
        @(posedge clk);
        #1;
        runInference($urandom_range(0, 13), 4'($urandom), 1);

        // Reset while the core is running.
        sendFrame(1'b1, 100, N, N - 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        globalRstN = 1'b0;
        #1;
        checkAllZero("reset_in_run");
        releaseReset();
        sendFrame(1'b1, 50, N, N - 1);
        runInference($urandom_range(0, 15), 4'($urandom), $urandom_range(0, 4));

        // A couple of fully randomised frames.
        for (int f = 0; f < 2; f++) begin
            sendFrame(1'b1, $urandom_range(30, 100), N, N - 1);
            runInference($urandom_range(0, 15), 4'($urandom), $urandom_range(0, 4));
        end

        finishRun();
    end

endmodule
